adder_share_arb: RTL
====================

Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined carry-in adder among NREQ requesters.
- Each cycle it picks at most one requester with valid operands and issues them into an internal LAT-stage adder pipeline. The pipeline has the same registered-output structure as the team's 2-stage full adder.
- Each result is returned on a shared response bus tagged with the requester ID.
- Sits between operand producers and the arithmetic datapath.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- WIDTH, 2, operand and sum width in bits.
- LAT, 2, adder pipeline depth in cycles; >=1.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- hold  input  1  when 1, no new grant is issued; the pipeline keeps draining.
- req_valid  input  NREQ  per-requester operand valid.
- req_a  input  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b, packed the same way.
- req_cin  input  NREQ  carry-in per requester.
- req_ready  output  NREQ  one-hot grant; combinational.
- rsp_valid  output  1  result valid; registered.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_sum  output  WIDTH  sum bits.
- rsp_cout  output  1  carry-out.
- inflight  output  $clog2(LAT+1)  number of operations currently in the pipeline.

Behaviour:
- Reset: synchronous. When rst_n=0 at a rising edge:
  - rr_ptr=0.
  - All pipeline valid bits, rsp_valid, rsp_id, rsp_sum, rsp_cout and inflight go to 0.
  - req_ready=0 while rst_n=0.
  - In-flight operations are discarded and never produce a response.
- Grant:
  - If hold=0 and rst_n=1, req_ready[g]=1 for the first i with req_valid[i]=1, searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - At most one bit of req_ready is high. req_ready=0 when no requester is valid or hold=1.
  - req_ready never asserts for a requester whose req_valid is 0.
- Transfer: occurs when req_valid[g] & req_ready[g]. On that edge, rr_ptr = (g+1) mod NREQ. With no transfer, rr_ptr is unchanged.
- Arithmetic:
  - {cout,sum} = a + b + cin, computed at full width WIDTH+1. No overflow is lost.
  - Example: WIDTH=2, a=3, b=3, cin=1 gives sum=3, cout=1.
- Latency:
  - A transfer in cycle N gives rsp_valid=1 in cycle N+LAT, with rsp_id=g and that result.
  - Issue rate is one per cycle; back-to-back transfers give back-to-back responses in issue order.
  - There is no response backpressure; the consumer must accept every rsp_valid cycle.
- Idle output: when rsp_valid=0, rsp_id, rsp_sum and rsp_cout hold their last values. They are not zeroed.
- Operand hold-off: a requester must keep a, b and cin stable while req_valid=1 and it is not granted. The arbiter samples operands only in the transfer cycle.
- hold:
  - Asserting hold mid-stream stops new grants from that cycle on.
  - Operations already issued complete and respond at their normal times.
  - Deasserting hold resumes arbitration from the current rr_ptr.
- inflight:
  - Increments on a transfer and decrements when rsp_valid is issued.
  - A transfer and a response in the same cycle leave it unchanged.
  - Range is 0..LAT.
- Fairness: with all NREQ requesters continuously valid and hold=0, grants rotate 0,1,...,NREQ-1,0,...
  - Maximum wait for a valid requester is NREQ-1 cycles of other grants.
- Single requester: a requester that stays valid alone is granted every cycle. rr_ptr keeps moving past it and wraps back.

Test Plan:
1. Reset, then req_valid=0001, a0=2, b0=1, cin0=1 for one cycle (cycle 5). Expect req_ready=0001 in cycle 5; rsp_valid=1 in cycle 7 with rsp_id=0, sum=0, cout=1; inflight goes 1,1,0.
2. req_valid=1111 held for 8 cycles from rr_ptr=0. Expect grant order 0,1,2,3,0,1,2,3. rsp_id follows the same sequence delayed by 2 cycles, with no bubbles.
3. req_valid=1010 with rr_ptr=0 and all operands max (a=3, b=3, cin=1). Expect grants 1,3,1,3, and every response sum=3, cout=1.
4. Grant requester 2 in cycle N, then hold=1 in cycles N+1..N+4 with all requesters valid. Expect no req_ready during hold; the requester-2 response still appears in cycle N+2. After hold drops, the first grant is requester 3.
5. Issue requesters 0 and 1 back-to-back, then drive rst_n=0 in the cycle after the second issue. Expect no rsp_valid afterwards; inflight=0, rr_ptr=0, and the next grant with req_valid=1111 goes to requester 0.
6. Randomised operands with an exhaustive sweep of all 32 (a,b,cin) combinations through requester 0. Expect every response equal to a+b+cin exactly 2 cycles after transfer, checked by a concurrent assertion.

Source files
------------

// File: rtl/adder_share_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_share_arb_if
//  Purpose  : Bundles the request and response signals of the shared-adder
//             arbiter.
//             master - operand producer / result consumer side
//             slave  - arbiter side
//  Signals  : hold, req_valid[NREQ], req_a/req_b[NREQ*WIDTH], req_cin[NREQ],
//             req_ready[NREQ], rsp_valid, rsp_id[IDW], rsp_sum[WIDTH],
//             rsp_cout, inflight[$clog2(LAT+1)]
//  Revision : 1.0 - initial release
// ============================================================================
interface adder_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2,
    parameter int LAT   = 2,
    parameter int IDW   = $clog2(NREQ)
);
    localparam int CW = $clog2(LAT + 1);

    logic                    hold;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ-1:0]         req_cin;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic [IDW-1:0]          rsp_id;
    logic [WIDTH-1:0]        rsp_sum;
    logic                    rsp_cout;
    logic [CW-1:0]           inflight;

    modport master (
        output hold, req_valid, req_a, req_b, req_cin,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, inflight
    );

    modport slave (
        input  hold, req_valid, req_a, req_b, req_cin,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, inflight
    );
endinterface
`default_nettype wire

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : adder_share_arb
//  Purpose  : Round-robin arbiter that shares one LAT-stage pipelined
//             carry-in adder among NREQ requesters. Results come back on a
//             shared response bus tagged with the requester index.
//  Ports    : clk   - rising-edge clock
//             rst_n - synchronous active-low reset
//             bus   - adder_share_arb_if.slave (requests, grants, responses,
//                     in-flight count)
//  Revision : 1.0 - initial release
// ============================================================================
module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2,
    parameter int LAT   = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus
);
    localparam int             CW      = $clog2(LAT + 1);
    localparam logic [IDW:0]   c_NREQ  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] c_LAST  = IDW'(NREQ - 1);

    logic [IDW-1:0]              r_rr_ptr;
    logic [LAT-1:0]              r_v;
    logic [LAT-1:0][IDW-1:0]     r_id;
    logic [LAT-1:0][WIDTH:0]     r_res;
    logic [CW-1:0]               r_inflight;

    logic [WIDTH-1:0]            w_a [NREQ];
    logic [WIDTH-1:0]            w_b [NREQ];
    logic [NREQ-1:0]             w_grant;
    logic [IDW-1:0]              w_gnt_id;
    logic                        w_xfer;
    logic [WIDTH:0]              w_res;
    logic [IDW:0]                w_pos;

    // Unpack the flat operand buses so the grant mux can index by requester.
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_a[i] = bus.req_a[i*WIDTH +: WIDTH];
            assign w_b[i] = bus.req_b[i*WIDTH +: WIDTH];
        end
    endgenerate

    // Search upward from r_rr_ptr with wrap-around; first valid requester
    // wins. The sum is formed here so stage 0 already holds the result and
    // later stages only delay it.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_xfer   = 1'b0;
        w_res    = '0;
        w_pos    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_pos >= c_NREQ) begin
                w_pos = w_pos - c_NREQ;
            end
            if (rst_n && !bus.hold && !w_xfer && bus.req_valid[w_pos[IDW-1:0]]) begin
                w_xfer                   = 1'b1;
                w_grant[w_pos[IDW-1:0]]  = 1'b1;
                w_gnt_id                 = w_pos[IDW-1:0];
                w_res = {1'b0, w_a[w_pos[IDW-1:0]]}
                      + {1'b0, w_b[w_pos[IDW-1:0]]}
                      + {{WIDTH{1'b0}}, bus.req_cin[w_pos[IDW-1:0]]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_v        <= '0;
            r_id       <= '0;
            r_res      <= '0;
            r_inflight <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_gnt_id == c_LAST) ? '0 : w_gnt_id + IDW'(1);
            end

            r_v[0] <= w_xfer;
            if (w_xfer) begin
                r_id[0]  <= w_gnt_id;
                r_res[0] <= w_res;
            end

            // Data only moves with a valid token, so the last stage keeps
            // its previous result visible while rsp_valid is low.
            for (int s = 1; s < LAT; s++) begin
                r_v[s] <= r_v[s-1];
                if (r_v[s-1]) begin
                    r_id[s]  <= r_id[s-1];
                    r_res[s] <= r_res[s-1];
                end
            end

            // An operation counts as in flight up to and including its
            // response cycle.
            r_inflight <= r_inflight + CW'(w_xfer) - CW'(r_v[LAT-1]);
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_v[LAT-1];
    assign bus.rsp_id    = r_id[LAT-1];
    assign bus.rsp_sum   = r_res[LAT-1][WIDTH-1:0];
    assign bus.rsp_cout  = r_res[LAT-1][WIDTH];
    assign bus.inflight  = r_inflight;

endmodule
`default_nettype wire
